pc_update_ctrl: RTL and testbench
=================================

PC_UPDATE_CTRL -- requirements
Module: pc_update_ctrl

Interface
REQ-001 Parameter RESET_VEC, default 8'h0A: PC value expected after reset; reported on mem_addr until the first fetch.
REQ-002 Parameter INCR, default 1: sequential PC step, unsigned 8-bit.
REQ-003 clock  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 run  input  1  fetching enabled while high.
REQ-006 SaidaPC  input  8  current PC value from the PC register.
REQ-007 EntradaPC  output  8  next PC value driven to the PC register.
REQ-008 EscPC  output  1  PC write enable; one-cycle pulse per update.
REQ-009 mem_req  output  1  instruction-memory request.
REQ-010 mem_addr  output  8  fetch address, equal to SaidaPC while mem_req=1.
REQ-011 mem_ack  input  1  memory response; mem_rdata is valid in the same cycle.
REQ-012 mem_rdata  input  16  fetched instruction word.
REQ-013 instr_out  output  16  last fetched instruction, held between fetches.
REQ-014 instr_valid  output  1  one-cycle pulse when instr_out updates.
REQ-015 branch_req  input  1  one-cycle redirect request.
REQ-016 branch_target  input  8  redirect address, sampled with branch_req.
REQ-017 stall  input  1  blocks the PC update while high.
REQ-018 fetch_count  output  8  completed fetches, wraps 8'hFF->8'h00.
REQ-019 trap  output  1  sticky wrap trap (REQ-040).

Function
REQ-020 FSM states: IDLE, REQ, WAIT, UPD, HALT.
REQ-021 IDLE: all outputs inactive; go to REQ on the next edge when run=1.
REQ-022 REQ: mem_req=1 and mem_addr=SaidaPC; go to WAIT on the next edge, or to UPD on that edge if mem_ack=1.
REQ-023 WAIT: mem_req stays 1 and mem_addr stays stable until mem_ack=1 is sampled; no timeout.
REQ-024 On the edge that samples mem_ack=1: instr_out<=mem_rdata, instr_valid=1 for the following cycle, fetch_count increments, FSM goes to UPD.
REQ-025 mem_req deasserts in the cycle after mem_ack is sampled; a mem_ack seen outside REQ/WAIT is ignored.
REQ-026 UPD with stall=0: EscPC=1 for exactly one cycle; EntradaPC=redirect target if a redirect applies, else (SaidaPC+INCR) mod 256.
REQ-027 UPD with stall=1: EscPC=0; FSM stays in UPD, and the redirect decision is re-evaluated every cycle.
REQ-028 After the update cycle: go to REQ if run=1, else IDLE.
REQ-029 A branch_req arriving in IDLE, REQ or WAIT latches branch_target into a pending register; a later branch_req overwrites it.
REQ-030 A branch_req arriving in the UPD update cycle takes priority over the pending value; the pending register clears on every update.
REQ-031 Deasserting run during REQ/WAIT does not abort the transaction; the fetch and update complete, then the FSM goes to IDLE.
REQ-032 EscPC is 0 in every state other than UPD, and when EscPC=0 EntradaPC equals SaidaPC.
REQ-033 Fetch-to-update latency is one cycle after the mem_ack edge, with no stall.
REQ-034 Zero-wait memory (mem_ack=1 in REQ) gives 2 cycles per instruction.

Reset
REQ-035 reset=0 forces IDLE asynchronously: mem_req=0, EscPC=0, instr_valid=0, instr_out=16'h0000, fetch_count=0, trap=0, pending redirect cleared, mem_addr=RESET_VEC.
REQ-036 A reset during WAIT abandons the transaction; a late mem_ack is ignored per REQ-025.
REQ-037 Reset release takes effect on the first rising edge with reset=1.

Configuration
REQ-038 Macro PC_WRAP_TRAP_EN selects the sequential-wrap behaviour.
REQ-039 Without PC_WRAP_TRAP_EN: sequential increment wraps modulo 256 silently; trap is tied 0; HALT is unreachable.
REQ-040 With PC_WRAP_TRAP_EN: a sequential update whose SaidaPC+INCR exceeds 8'hFF (no redirect) suppresses EscPC, sets trap=1, and enters HALT; HALT is left only by reset; a redirect never traps.

Verification
REQ-041 Reset release, run=1, SaidaPC=8'h0A, mem_ack one cycle after mem_req, mem_rdata=16'h1234 -> mem_addr=8'h0A, instr_out=16'h1234, instr_valid pulse, EscPC pulse with EntradaPC=8'h0B.
REQ-042 branch_req with target 8'h40 during WAIT -> the next update drives EntradaPC=8'h40; the following update is sequential.
REQ-043 stall=1 for 3 cycles in UPD, with branch_req target 8'h20 on the 2nd stall cycle -> EscPC stays 0 for 3 cycles, then pulses with EntradaPC=8'h20.
REQ-044 run dropped mid-WAIT with mem_ack 4 cycles later -> fetch completes, one EscPC pulse, FSM goes to IDLE with mem_req=0.
REQ-045 SaidaPC=8'hFF, sequential update -> without the macro, EntradaPC=8'h00 and trap=0; with PC_WRAP_TRAP_EN, EscPC=0, trap=1, and the FSM stays in HALT until reset.
REQ-046 reset asserted in WAIT, then mem_ack pulsed -> all outputs at reset values; instr_valid and fetch_count unchanged.

Source files
------------

// File: rtl/pc_update_ctrl_if.sv
// Bundles the PC-register, instruction-memory, branch and status signals of pc_update_ctrl.
// master is the controller side, slave is the PC register / memory / pipeline side.
interface pc_update_ctrl_if;
    logic        run;
    logic [7:0]  SaidaPC;
    logic [7:0]  EntradaPC;
    logic        EscPC;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] instr_out;
    logic        instr_valid;
    logic        branch_req;
    logic [7:0]  branch_target;
    logic        stall;
    logic [7:0]  fetch_count;
    logic        trap;

    modport master (
        input  run, SaidaPC, mem_ack, mem_rdata, branch_req, branch_target, stall,
        output EntradaPC, EscPC, mem_req, mem_addr, instr_out, instr_valid, fetch_count, trap
    );

    modport slave (
        output run, SaidaPC, mem_ack, mem_rdata, branch_req, branch_target, stall,
        input  EntradaPC, EscPC, mem_req, mem_addr, instr_out, instr_valid, fetch_count, trap
    );
endinterface

// File: rtl/pc_update_ctrl.sv
// Fetch/PC-update controller: requests an instruction at SaidaPC, then writes the next PC.
// Define PC_WRAP_TRAP_EN to trap (and halt) on a sequential PC wrap instead of wrapping silently.
module pc_update_ctrl #(
    parameter logic [7:0] RESET_VEC = 8'h0A,
    parameter logic [7:0] INCR      = 8'd1
) (
    input  logic               clock,
    input  logic               reset,
    pc_update_ctrl_if.master   bus
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_UPD  = 3'd3;
    localparam logic [2:0] S_HALT = 3'd4;

    logic [2:0]  state;
    logic [2:0]  state_next;
    logic [7:0]  pending_target;
    logic        pending_valid;
    logic [7:0]  last_addr;
    logic [15:0] instr_q;
    logic        instr_valid_q;
    logic [7:0]  fetch_cnt_q;

    logic        in_fetch;
    logic        ack_taken;
    logic        redirect;
    logic        upd_cycle;
    logic        wrap_trap;
    logic [7:0]  redirect_pc;
    logic [7:0]  seq_pc;
    logic [7:0]  next_pc;

    assign in_fetch    = (state == S_REQ) || (state == S_WAIT);
    assign ack_taken   = in_fetch && bus.mem_ack;
    assign upd_cycle   = (state == S_UPD) && !bus.stall;

    // A branch arriving in the update cycle itself beats the pending one.
    assign redirect    = bus.branch_req || pending_valid;
    assign redirect_pc = bus.branch_req ? bus.branch_target : pending_target;
    assign seq_pc      = bus.SaidaPC + INCR;
    assign next_pc     = redirect ? redirect_pc : seq_pc;

`ifdef PC_WRAP_TRAP_EN
    logic [8:0] seq_sum;
    logic       trap_q;

    assign seq_sum   = {1'b0, bus.SaidaPC} + {1'b0, INCR};
    assign wrap_trap = !redirect && seq_sum[8];
    assign bus.trap  = trap_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            trap_q <= 1'b0;
        end else if (upd_cycle && wrap_trap) begin
            trap_q <= 1'b1;
        end
    end
`else
    assign wrap_trap = 1'b0;
    assign bus.trap  = 1'b0;
`endif

    assign bus.EscPC       = upd_cycle && !wrap_trap;
    assign bus.EntradaPC   = bus.EscPC ? next_pc : bus.SaidaPC;
    assign bus.mem_req     = in_fetch;
    // Address is captured in REQ so it cannot move while WAIT holds the request.
    assign bus.mem_addr    = (state == S_REQ) ? bus.SaidaPC : last_addr;
    assign bus.instr_out   = instr_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.fetch_count = fetch_cnt_q;

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (bus.run) state_next = S_REQ;
            S_REQ:  state_next = bus.mem_ack ? S_UPD : S_WAIT;
            S_WAIT: if (bus.mem_ack) state_next = S_UPD;
            S_UPD: begin
                if (!bus.stall) begin
                    if (wrap_trap)    state_next = S_HALT;
                    else if (bus.run) state_next = S_REQ;
                    else              state_next = S_IDLE;
                end
            end
            S_HALT:  state_next = S_HALT;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= S_IDLE;
            pending_target <= 8'h00;
            pending_valid  <= 1'b0;
            last_addr      <= RESET_VEC;
            instr_q        <= 16'h0000;
            instr_valid_q  <= 1'b0;
            fetch_cnt_q    <= 8'h00;
        end else begin
            state         <= state_next;
            instr_valid_q <= ack_taken;
            if (state == S_REQ) begin
                last_addr <= bus.SaidaPC;
            end
            if (ack_taken) begin
                instr_q     <= bus.mem_rdata;
                fetch_cnt_q <= fetch_cnt_q + 8'd1;
            end
            // Stall cycles keep collecting branches so the eventual update sees the latest one.
            if (upd_cycle) begin
                pending_valid <= 1'b0;
            end else if (bus.branch_req && state != S_HALT) begin
                pending_valid  <= 1'b1;
                pending_target <= bus.branch_target;
            end
        end
    end

endmodule

// File: tb/tb_pc_update_ctrl.sv
// Scoreboard bench for pc_update_ctrl: directed fetches with a latency-programmable memory model.
// Define PC_WRAP_TRAP_EN here as for the RTL to select the wrap expectations.
module tb_pc_update_ctrl;

    logic clock;
    logic reset;

    pc_update_ctrl_if bus();

    pc_update_ctrl #(.RESET_VEC(8'h0A), .INCR(8'd1)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]  exp_addr_q[$];
    logic [15:0] exp_instr_q[$];
    logic [7:0]  exp_pc_q[$];
    logic [15:0] mem_data_q[$];

    int          ack_delay;
    logic        mem_en;
    logic        force_ack;
    int          req_cnt;
    logic [7:0]  pc_model;
    logic        prev_req;
    logic [7:0]  held_addr;
    int          gap;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Environment PC register fed back to the controller.
    always @(posedge clock or negedge reset) begin
        if (!reset)           pc_model <= 8'h0A;
        else if (bus.EscPC)   pc_model <= bus.EntradaPC;
    end
    assign bus.SaidaPC = pc_model;

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic report_unexpected(input string name, input logic [15:0] actual);
        checks++;
        errors++;
        $display("[TB] FAIL %s: unexpected output %h with nothing expected", name, actual);
    endtask

    task automatic applyStimulus(input logic [7:0] addr, input logic [15:0] data,
                                 input logic [7:0] pc_next, input bit has_update);
        exp_addr_q.push_back(addr);
        mem_data_q.push_back(data);
        exp_instr_q.push_back(data);
        if (has_update) exp_pc_q.push_back(pc_next);
    endtask

    task automatic wait_cycle();
        @(posedge clock);
        #2;
    endtask

    task automatic wait_update(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            wait_cycle();
            seen = bus.EscPC;
        end
        checkOutput(name, {15'd0, seen}, 16'd1);
    endtask

    task automatic wait_valid(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            wait_cycle();
            seen = bus.instr_valid;
        end
        checkOutput(name, {15'd0, seen}, 16'd1);
    endtask

    // Memory model: acks after ack_delay request cycles, or echoes force_ack when idle.
    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 16'h0000;
        req_cnt       = 0;
        forever begin
            @(posedge clock);
            #1;
            if (bus.mem_req && mem_en) begin
                if (req_cnt == ack_delay && mem_data_q.size() > 0) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = mem_data_q.pop_front();
                end else begin
                    bus.mem_ack = 1'b0;
                end
                req_cnt++;
            end else begin
                req_cnt       = 0;
                bus.mem_ack   = force_ack;
                bus.mem_rdata = force_ack ? 16'hBEEF : 16'h0000;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a request, instruction or PC write.
    initial begin
        prev_req  = 1'b0;
        held_addr = 8'h00;
        forever begin
            @(negedge clock);
            if (!reset) begin
                prev_req = 1'b0;
            end else begin
                if (bus.mem_req && !prev_req) begin
                    if (exp_addr_q.size() == 0) report_unexpected("fetch_addr", {8'h00, bus.mem_addr});
                    else checkOutput("fetch_addr", {8'h00, bus.mem_addr}, {8'h00, exp_addr_q.pop_front()});
                    held_addr = bus.mem_addr;
                end else if (bus.mem_req) begin
                    checkOutput("addr_stable", {8'h00, bus.mem_addr}, {8'h00, held_addr});
                end
                if (bus.instr_valid) begin
                    if (exp_instr_q.size() == 0) report_unexpected("instr_out", bus.instr_out);
                    else checkOutput("instr_out", bus.instr_out, exp_instr_q.pop_front());
                end
                if (bus.EscPC) begin
                    if (exp_pc_q.size() == 0) report_unexpected("EntradaPC", {8'h00, bus.EntradaPC});
                    else checkOutput("EntradaPC", {8'h00, bus.EntradaPC}, {8'h00, exp_pc_q.pop_front()});
                end else begin
                    checkOutput("EntradaPC_hold", {8'h00, bus.EntradaPC}, {8'h00, bus.SaidaPC});
                end
                prev_req = bus.mem_req;
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset             = 1'b0;
        bus.run           = 1'b0;
        bus.stall         = 1'b0;
        bus.branch_req    = 1'b0;
        bus.branch_target = 8'h00;
        mem_en            = 1'b1;
        force_ack         = 1'b0;
        ack_delay         = 1;

        repeat (3) wait_cycle();
        checkOutput("rst_mem_req",     {15'd0, bus.mem_req},     16'd0);
        checkOutput("rst_EscPC",       {15'd0, bus.EscPC},       16'd0);
        checkOutput("rst_instr_valid", {15'd0, bus.instr_valid}, 16'd0);
        checkOutput("rst_instr_out",   bus.instr_out,            16'h0000);
        checkOutput("rst_fetch_count", {8'h00, bus.fetch_count}, 16'h0000);
        checkOutput("rst_trap",        {15'd0, bus.trap},        16'd0);
        checkOutput("rst_mem_addr",    {8'h00, bus.mem_addr},    16'h000A);

        // Basic fetch with one wait cycle.
        applyStimulus(8'h0A, 16'h1234, 8'h0B, 1'b1);
        reset   = 1'b1;
        bus.run = 1'b1;
        wait_update("f1_update");
        checkOutput("f1_count", {8'h00, bus.fetch_count}, 16'h0001);

        // Branch during WAIT redirects, the next update is sequential from the target.
        ack_delay = 2;
        applyStimulus(8'h0B, 16'h5678, 8'h40, 1'b1);
        wait_cycle();
        wait_cycle();
        bus.branch_req    = 1'b1;
        bus.branch_target = 8'h40;
        wait_cycle();
        bus.branch_req    = 1'b0;
        wait_update("f2_update");
        ack_delay = 1;
        applyStimulus(8'h40, 16'h9ABC, 8'h41, 1'b1);
        wait_update("f3_update");

        // Three stall cycles in UPD with a branch on the second one.
        applyStimulus(8'h41, 16'hDEF0, 8'h20, 1'b1);
        wait_cycle();
        bus.stall = 1'b1;
        wait_valid("f4_valid");
        checkOutput("stall1_EscPC", {15'd0, bus.EscPC}, 16'd0);
        wait_cycle();
        checkOutput("stall2_EscPC", {15'd0, bus.EscPC}, 16'd0);
        bus.branch_req    = 1'b1;
        bus.branch_target = 8'h20;
        wait_cycle();
        checkOutput("stall3_EscPC", {15'd0, bus.EscPC}, 16'd0);
        bus.branch_req    = 1'b0;
        wait_cycle();
        bus.stall = 1'b0;

        // Zero-wait memory: two cycles per instruction.
        ack_delay = 0;
        applyStimulus(8'h20, 16'h4444, 8'h21, 1'b1);
        applyStimulus(8'h21, 16'h5555, 8'h22, 1'b1);
        wait_update("f5_update");
        gap = 0;
        for (int i = 0; i < 20; i++) begin
            wait_cycle();
            gap++;
            if (bus.EscPC) break;
        end
        checkOutput("zero_wait_gap", gap[15:0], 16'd2);

        // run dropped mid-WAIT: the fetch completes, then the controller idles.
        ack_delay = 5;
        applyStimulus(8'h22, 16'h6666, 8'h23, 1'b1);
        wait_cycle();
        wait_cycle();
        bus.run = 1'b0;
        wait_update("f7_update");
        wait_cycle();
        checkOutput("idle_mem_req", {15'd0, bus.mem_req}, 16'd0);
        repeat (2) wait_cycle();
        checkOutput("idle_mem_req2", {15'd0, bus.mem_req}, 16'd0);
        checkOutput("f7_count", {8'h00, bus.fetch_count}, 16'h0007);
        checkOutput("f7_instr_hold", bus.instr_out, 16'h6666);

        // Redirect to 8'hFF, then a sequential update from 8'hFF.
        ack_delay = 2;
        applyStimulus(8'h23, 16'h7777, 8'hFF, 1'b1);
        bus.run = 1'b1;
        wait_cycle();
        wait_cycle();
        bus.branch_req    = 1'b1;
        bus.branch_target = 8'hFF;
        wait_cycle();
        bus.branch_req    = 1'b0;
        wait_update("f8_update");
        ack_delay = 1;
`ifdef PC_WRAP_TRAP_EN
        applyStimulus(8'hFF, 16'h8888, 8'h00, 1'b0);
        wait_valid("f9_valid");
        checkOutput("wrap_EscPC", {15'd0, bus.EscPC}, 16'd0);
        wait_cycle();
        checkOutput("wrap_trap", {15'd0, bus.trap}, 16'd1);
        checkOutput("halt_mem_req", {15'd0, bus.mem_req}, 16'd0);
        repeat (3) wait_cycle();
        checkOutput("halt_trap_sticky", {15'd0, bus.trap}, 16'd1);
        checkOutput("halt_mem_req2", {15'd0, bus.mem_req}, 16'd0);
        bus.run = 1'b0;
`else
        applyStimulus(8'hFF, 16'h8888, 8'h00, 1'b1);
        wait_update("f9_update");
        bus.run = 1'b0;
        checkOutput("wrap_trap", {15'd0, bus.trap}, 16'd0);
        wait_cycle();
        checkOutput("wrap_idle_mem_req", {15'd0, bus.mem_req}, 16'd0);
`endif
        checkOutput("f9_count", {8'h00, bus.fetch_count}, 16'h0009);

        // Reset, then reset again in WAIT and pulse a stray mem_ack.
        reset = 1'b0;
        #1;
        checkOutput("rst2_trap", {15'd0, bus.trap}, 16'd0);
        checkOutput("rst2_fetch_count", {8'h00, bus.fetch_count}, 16'h0000);
        wait_cycle();
        reset   = 1'b1;
        bus.run = 1'b1;
        mem_en  = 1'b0;
        exp_addr_q.push_back(8'h0A);
        wait_cycle();
        wait_cycle();
        checkOutput("wait_mem_req", {15'd0, bus.mem_req}, 16'd1);
        reset   = 1'b0;
        bus.run = 1'b0;
        #1;
        checkOutput("rst3_mem_req", {15'd0, bus.mem_req}, 16'd0);
        checkOutput("rst3_mem_addr", {8'h00, bus.mem_addr}, 16'h000A);
        wait_cycle();
        reset     = 1'b1;
        force_ack = 1'b1;
        wait_cycle();
        force_ack = 1'b0;
        wait_cycle();
        checkOutput("late_ack_valid", {15'd0, bus.instr_valid}, 16'd0);
        checkOutput("late_ack_count", {8'h00, bus.fetch_count}, 16'h0000);
        checkOutput("late_ack_instr", bus.instr_out, 16'h0000);
        checkOutput("late_ack_mem_req", {15'd0, bus.mem_req}, 16'd0);
        checkOutput("late_ack_EscPC", {15'd0, bus.EscPC}, 16'd0);
        checkOutput("late_ack_mem_addr", {8'h00, bus.mem_addr}, 16'h000A);

        wait_cycle();
        checkOutput("left_addr",  exp_addr_q.size(),  16'd0);
        checkOutput("left_instr", exp_instr_q.size(), 16'd0);
        checkOutput("left_pc",    exp_pc_q.size(),    16'd0);
        checkOutput("left_data",  mem_data_q.size(),  16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
